// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first. Double-flop synchronises RXD, detects the start
// edge and samples each bit at mid-bit; reports good bytes and bad stop bits.
module uart_rx #(
    parameter int CLKS_PER_BIT = 5000,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       RXD,
    output logic [7:0] DATA,
    output logic       VALID,
    output logic       FRAME_ERR,
    output logic       BUSY
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA_ST,
        STOP
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [2:0]      bit_idx_reg, bit_idx_next;
    logic [7:0]      shift_reg, shift_next;
    logic [7:0]      data_reg, data_next;
    logic            valid_reg, valid_next;
    logic            frame_err_reg, frame_err_next;
    logic            rxd_meta_reg, rxd_s_reg, rxd_p_reg;

    // Sync chain and previous-sample flop idle high so reset never looks like a start edge
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rxd_meta_reg <= 1'b1;
            rxd_s_reg    <= 1'b1;
            rxd_p_reg    <= 1'b1;
        end else begin
            rxd_meta_reg <= RXD;
            rxd_s_reg    <= rxd_meta_reg;
            rxd_p_reg    <= rxd_s_reg;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            bit_idx_reg   <= 3'd0;
            shift_reg     <= 8'h00;
            data_reg      <= 8'h00;
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            bit_idx_reg   <= bit_idx_next;
            shift_reg     <= shift_next;
            data_reg      <= data_next;
            valid_reg     <= valid_next;
            frame_err_reg <= frame_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg + 1'b1;
        bit_idx_next   = bit_idx_reg;
        shift_next     = shift_reg;
        data_next      = data_reg;
        valid_next     = 1'b0;
        frame_err_next = 1'b0;

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                // Only a genuine 1->0 transition arms reception, so a held-low line stays parked
                if (rxd_p_reg && !rxd_s_reg) begin
                    state_next = START;
                end
            end
            START: begin
                if (cnt_reg == HALF_LAST) begin
                    cnt_next     = '0;
                    bit_idx_next = 3'd0;
                    state_next   = rxd_s_reg ? IDLE : DATA_ST;
                end
            end
            DATA_ST: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next                = '0;
                    shift_next[bit_idx_reg] = rxd_s_reg;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end
            end
            STOP: begin
                // Leave at mid stop bit so a following start edge is not missed
                if (cnt_reg == BIT_LAST) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                    if (rxd_s_reg) begin
                        data_next  = shift_reg;
                        valid_next = 1'b1;
                    end else begin
                        frame_err_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign DATA      = data_reg;
    assign VALID     = valid_reg;
    assign FRAME_ERR = frame_err_reg;
    assign BUSY      = (state_reg != IDLE);

endmodule
